// File: rtl/glyph_fetch_ctrl_pkg.sv
// Shared definitions for the glyph fetch controller: FSM encoding, default
// text geometry, glyph size and the row-base helper.
package glyph_fetch_ctrl_pkg;

    localparam int DEF_COLS     = 80;
    localparam int DEF_ROWS     = 30;
    localparam int GLYPH_W      = 8;
    localparam int GLYPH_H      = 16;
    localparam int DRAIN_CYCLES = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef logic [GLYPH_W-1:0] glyph_bits_t;

    function automatic logic [4:0] row_clamp(input logic [4:0] row, input int rows);
        return (int'(row) >= rows) ? 5'(rows - 1) : row;
    endfunction

    // Unsigned 12-bit start address of a text row in character RAM.
    function automatic logic [11:0] row_base(input logic [4:0] row, input int cols,
                                             input int rows);
        return 12'(int'(row_clamp(row, rows)) * cols);
    endfunction

endpackage

// File: rtl/glyph_fetch_ctrl_if.sv
// Bus bundle between the glyph fetch controller (slave) and its
// surroundings: line request, character RAM, font ROM and display read port.
interface glyph_fetch_ctrl_if;
    import glyph_fetch_ctrl_pkg::*;

    logic        line_start;
    logic [4:0]  fetch_row;
    logic [3:0]  fetch_scanline;
    logic        char_rd_en;
    logic [11:0] char_addr;
    logic [7:0]  char_data;
    logic [7:0]  font_char;
    logic [3:0]  font_scanline;
    glyph_bits_t font_row;
    logic [6:0]  disp_col;
    glyph_bits_t disp_bits;
    logic        busy;
    logic        done;
    logic        overrun;

    modport master (
        output line_start, fetch_row, fetch_scanline, char_data, font_row, disp_col,
        input  char_rd_en, char_addr, font_char, font_scanline, disp_bits, busy, done, overrun
    );

    modport slave (
        input  line_start, fetch_row, fetch_scanline, char_data, font_row, disp_col,
        output char_rd_en, char_addr, font_char, font_scanline, disp_bits, busy, done, overrun
    );

endinterface

// File: rtl/glyph_line_buf.sv
// Ping-pong glyph line buffer: two banks of COLS x 8 bits, one write port and
// one registered read port that returns 0x00 for columns beyond COLS.
module glyph_line_buf
    import glyph_fetch_ctrl_pkg::*;
#(
    parameter int COLS = DEF_COLS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en_i,
    input  logic        wr_bank_i,
    input  logic [6:0]  wr_col_i,
    input  glyph_bits_t wr_data_i,
    input  logic        rd_bank_i,
    input  logic [6:0]  rd_col_i,
    output glyph_bits_t rd_data_o
);

    glyph_bits_t mem_q [2][COLS];
    glyph_bits_t rd_data_q;

    // NOTE: the storage array has no reset so it maps onto plain RAM and keeps
    // its contents across a reset; only the read register is reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_bank_i][wr_col_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_col_i < 7'(COLS)) begin
            rd_data_q <= mem_q[rd_bank_i][rd_col_i];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/glyph_fetch_ctrl.sv
// Fetches one glyph scanline for a whole text row into a ping-pong line buffer.
// Optional cursor inversion is enabled by defining GLYPH_FETCH_CURSOR_EN.
module glyph_fetch_ctrl
    import glyph_fetch_ctrl_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef GLYPH_FETCH_CURSOR_EN
    input  logic               cursor_en,
    input  logic [6:0]         cursor_col,
    input  logic [4:0]         cursor_row,
`endif
    glyph_fetch_ctrl_if.slave  bus
);

    localparam logic [6:0] LAST_COL  = 7'(COLS - 1);
    localparam logic       LAST_DRN  = 1'(DRAIN_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [11:0] base_q, base_d;
    logic [3:0]  scanline_q, scanline_d;
    logic [6:0]  col_q, col_d;
    logic        drain_q, drain_d;
    logic        wr_bank_q, wr_bank_d;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;

    // Column tags travelling alongside char_data (stage 1) and font_row (stage 2).
    logic        v1_q, v2_q;
    logic [6:0]  c1_q, c2_q;
    glyph_bits_t wr_data;

    // NOTE: every always_comb output gets a default first so no path leaves a
    // value unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        scanline_d = scanline_q;
        col_d      = col_q;
        drain_d    = drain_q;
        wr_bank_d  = wr_bank_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q | (bus.line_start && (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (bus.line_start) begin
                    base_d     = row_base(bus.fetch_row, COLS, ROWS);
                    scanline_d = bus.fetch_scanline;
                    wr_bank_d  = ~wr_bank_q;
                    col_d      = '0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    drain_d = 1'b0;
                    state_d = ST_DRAIN;
                end else begin
                    col_d = col_q + 7'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == LAST_DRN) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            scanline_q <= '0;
            col_q      <= '0;
            drain_q    <= 1'b0;
            wr_bank_q  <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            c1_q       <= '0;
            c2_q       <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            scanline_q <= scanline_d;
            col_q      <= col_d;
            drain_q    <= drain_d;
            wr_bank_q  <= wr_bank_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            v1_q       <= bus.char_rd_en;
            c1_q       <= col_q;
            v2_q       <= v1_q;
            c2_q       <= c1_q;
        end
    end

`ifdef GLYPH_FETCH_CURSOR_EN
    logic [4:0] row_q;
    logic       cursor_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
        end else if (bus.line_start && (state_q == ST_IDLE)) begin
            row_q <= row_clamp(bus.fetch_row, ROWS);
        end
    end

    assign cursor_hit = cursor_en && (cursor_row == row_q) && (cursor_col == c2_q);
    assign wr_data    = bus.font_row ^ {GLYPH_W{cursor_hit}};
`else
    assign wr_data    = bus.font_row;
`endif

    assign bus.char_rd_en    = (state_q == ST_FETCH);
    assign bus.char_addr     = bus.char_rd_en ? (base_q + {5'd0, col_q}) : '0;
    assign bus.font_char     = bus.char_data;
    assign bus.font_scanline = scanline_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.done          = done_q;
    assign bus.overrun       = overrun_q;

    glyph_line_buf #(.COLS(COLS)) u_line_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (v2_q),
        .wr_bank_i (wr_bank_q),
        .wr_col_i  (c2_q),
        .wr_data_i (wr_data),
        .rd_bank_i (~wr_bank_q),
        .rd_col_i  (bus.disp_col),
        .rd_data_o (bus.disp_bits)
    );

endmodule

// File: tb/tb_glyph_fetch_ctrl.sv
// Self-checking bench for glyph_fetch_ctrl with character RAM / font ROM
// models and a per-bank line-buffer reference model.
module tb_glyph_fetch_ctrl;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
`ifdef GLYPH_FETCH_CURSOR_EN
    logic       cursor_en  = 1'b0;
    logic [6:0] cursor_col = '0;
    logic [4:0] cursor_row = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] char_mem [4096];
    bit         font_const;
    logic [7:0] exp_buf [2][128];
    bit         exp_ok  [2][128];
    int         exp_wr  = 0;
    bit         exp_ovr = 1'b0;

    always #5 clk = ~clk;

    glyph_fetch_ctrl_if bus ();

    glyph_fetch_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef GLYPH_FETCH_CURSOR_EN
        .cursor_en  (cursor_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
`endif
        .bus        (bus)
    );

    function automatic logic [7:0] font_fn(input logic [7:0] c, input logic [3:0] s);
        if (font_const) return 8'h18;
        return {c[2:0], c[7:3]} ^ {s, ~s};
    endfunction

    // Character RAM and font ROM: one-cycle read latency each.
    always @(posedge clk) begin
        bus.char_data <= char_mem[bus.char_addr];
        bus.font_row  <= font_fn(bus.font_char, bus.font_scanline);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff_row(input int row);
        return (row >= ROWS) ? ROWS - 1 : row;
    endfunction

    task automatic model_commit(input int row, input int sl);
        int base;
        logic [7:0] v;
        base = eff_row(row) * COLS;
        for (int c = 0; c < COLS; c++) begin
            v = font_fn(char_mem[base + c], 4'(sl));
`ifdef GLYPH_FETCH_CURSOR_EN
            if (cursor_en && eff_row(row) == int'(cursor_row) && c == int'(cursor_col))
                v = v ^ 8'hFF;
`endif
            exp_buf[exp_wr][c] = v;
            exp_ok[exp_wr][c]  = 1'b1;
        end
    endtask

    // One row fetch with cycle-exact checks; optional second start at ovr_k,
    // optional reset at rst_k (cycle indices counted from the sampling edge).
    task automatic run_fetch(input int row, input int sl, input int ovr_k, input int rst_k);
        int  base;
        bit  aborted;
        aborted = 1'b0;
        base = eff_row(row) * COLS;
        @(negedge clk);
        bus.line_start     = 1'b1;
        bus.fetch_row      = 5'(row);
        bus.fetch_scanline = 4'(sl);
        exp_wr ^= 1;
        for (int k = 0; k <= COLS + 3; k++) begin
            @(negedge clk);
            if (k == rst_k) begin
                rst_n = 1'b0;
                bus.line_start = 1'b0;
                #1;
                check("abort_busy",  32'(bus.busy), 32'd0);
                check("abort_rd_en", 32'(bus.char_rd_en), 32'd0);
                check("abort_addr",  32'(bus.char_addr), 32'd0);
                check("abort_done",  32'(bus.done), 32'd0);
                check("abort_disp",  32'(bus.disp_bits), 32'd0);
                for (int c = 0; c < 128; c++) exp_ok[exp_wr][c] = 1'b0;
                exp_wr  = 0;
                exp_ovr = 1'b0;
                aborted = 1'b1;
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            if (ovr_k >= 0 && k == ovr_k + 1) exp_ovr = 1'b1;
            check("busy",    32'(bus.busy), 32'(k <= COLS + 1));
            check("rd_en",   32'(bus.char_rd_en), 32'(k < COLS));
            if (k < COLS) check("char_addr", 32'(bus.char_addr), 32'(base + k));
            check("done",    32'(bus.done), 32'(k == COLS + 2));
            check("overrun", 32'(bus.overrun), 32'(exp_ovr));
            if (k == 1) check("font_scanline", 32'(bus.font_scanline), 32'(sl));
            bus.line_start = (k == ovr_k);
            if (k == ovr_k) bus.fetch_row = 5'($urandom);
        end
        if (!aborted) model_commit(row, sl);
    endtask

    task automatic disp_one(input int col);
        int b;
        b = exp_wr ^ 1;
        @(negedge clk);
        bus.disp_col = 7'(col);
        @(negedge clk);
        if (col >= COLS) check("disp_oob", 32'(bus.disp_bits), 32'd0);
        else if (exp_ok[b][col]) check("disp_bits", 32'(bus.disp_bits), 32'(exp_buf[b][col]));
    endtask

    task automatic disp_check(input int n);
        for (int i = 0; i < n; i++) disp_one(int'($urandom_range(0, 127)));
    endtask

    initial begin
        bus.line_start     = 1'b0;
        bus.fetch_row      = '0;
        bus.fetch_scanline = '0;
        bus.disp_col       = '0;
        font_const         = 1'b1;
        for (int i = 0; i < 4096; i++) char_mem[i] = 8'h41;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",    32'(bus.busy), 32'd0);
        check("rst_rd_en",   32'(bus.char_rd_en), 32'd0);
        check("rst_done",    32'(bus.done), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_addr",    32'(bus.char_addr), 32'd0);
        check("rst_disp",    32'(bus.disp_bits), 32'd0);
        rst_n = 1'b1;

        // Row 2 scanline 5 with constant RAM/ROM, then a swap to display it.
        run_fetch(2, 5, -1, -1);
        run_fetch(0, 0, -1, -1);
        for (int c = 0; c < COLS; c++) disp_one(c);
        disp_one(100);

        // Random character contents and rows, including clamped rows 30/31.
        font_const = 1'b0;
        for (int i = 0; i < 4096; i++) char_mem[i] = 8'($urandom);
        repeat (6) begin
            run_fetch(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), -1, -1);
            disp_check(6);
        end
        run_fetch(31, 9, -1, -1);
        run_fetch(30, 2, -1, -1);
        disp_check(8);

        // Second start while busy: ignored, sticky overrun, no extra toggle.
        run_fetch(int'($urandom_range(0, 29)), int'($urandom_range(0, 15)), 9, -1);
        run_fetch(int'($urandom_range(0, 29)), int'($urandom_range(0, 15)), -1, -1);
        disp_check(12);

        // Reset in mid-fetch; the untouched bank must survive it.
        if (exp_wr == 0) run_fetch(int'($urandom_range(0, 29)), 4, -1, -1);
        run_fetch(int'($urandom_range(0, 29)), 7, -1, 40);
        disp_check(12);
        run_fetch(int'($urandom_range(0, 29)), int'($urandom_range(0, 15)), -1, -1);
        run_fetch(int'($urandom_range(0, 29)), int'($urandom_range(0, 15)), -1, -1);
        disp_check(12);

`ifdef GLYPH_FETCH_CURSOR_EN
        font_const = 1'b1;
        cursor_en  = 1'b1;
        cursor_row = 5'd2;
        cursor_col = 7'd7;
        run_fetch(2, 3, -1, -1);
        run_fetch(0, 0, -1, -1);
        for (int c = 0; c < COLS; c++) disp_one(c);
        cursor_en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/glyph_fetch_ctrl.md
GLYPH_FETCH_CTRL -- requirements
Module: glyph_fetch_ctrl

Interface
REQ-001 Parameter COLS, default 80, text columns per row (1..127).
REQ-002 Parameter ROWS, default 30, text rows per screen (1..31).
REQ-003 clk  in  1  pixel clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 line_start  in  1  single-cycle pulse; requests a fetch of one glyph scanline for a whole text row.
REQ-006 fetch_row  in  5  text row to fetch, sampled with line_start.
REQ-007 fetch_scanline  in  4  glyph scanline 0-15, sampled with line_start.
REQ-008 char_rd_en  out  1  character RAM read strobe.
REQ-009 char_addr  out  12  character RAM address.
REQ-010 char_data  in  8  character code, valid one cycle after char_rd_en.
REQ-011 font_char  out  8  character code to the font ROM.
REQ-012 font_scanline  out  4  scanline to the font ROM.
REQ-013 font_row  in  8  glyph bits, valid one cycle after font_char/font_scanline.
REQ-014 disp_col  in  7  display-side column select.
REQ-015 disp_bits  out  8  registered glyph bits for disp_col from the display bank.
REQ-016 busy  out  1  fetch in progress.
REQ-017 done  out  1  single-cycle pulse when the row fetch completes.
REQ-018 overrun  out  1  sticky error flag.

Function
REQ-019 FSM states SHALL be IDLE, FETCH and DRAIN; reset state SHALL be IDLE.
REQ-020 IDLE: line_start SHALL latch fetch_scanline and base = fetch_row*COLS, toggle the write bank, and enter FETCH.
REQ-021 FETCH: char_rd_en SHALL be high for exactly COLS consecutive cycles, with char_addr = base+0 .. base+COLS-1; after the last column the FSM SHALL enter DRAIN.
REQ-022 Each returned char_data SHALL be driven on font_char in the same cycle, with font_scanline = the latched scanline (combinational pass-through; the ROM registers it).
REQ-023 font_row SHALL be written into the write bank at its column index one cycle after font_char; column pipeline depth is 2.
REQ-024 DRAIN SHALL last 2 cycles; after the final write, done SHALL pulse and the FSM SHALL return to IDLE.
REQ-025 Timing: for line_start sampled at edge E0, busy SHALL be high from E0+1 through E0+COLS+2, and done SHALL be high for the single cycle after edge E0+COLS+2.
REQ-026 Line buffer SHALL be two banks of COLS x 8 bits (ping-pong); the display bank SHALL be the bank not currently selected for writing.
REQ-027 disp_bits SHALL equal display_bank[disp_col] registered, with 1-cycle latency; for disp_col >= COLS it SHALL be 0x00.
REQ-028 line_start while busy SHALL be ignored (no restart, no bank toggle) and SHALL set overrun, which is cleared only by reset.
REQ-029 base arithmetic SHALL be unsigned 12-bit; fetch_row >= ROWS SHALL be clamped to ROWS-1.

Reset
REQ-030 During reset: state IDLE; char_rd_en, busy, done, overrun = 0; char_addr = 0; disp_bits = 0x00; write bank = 0; latched scanline = 0.
REQ-031 Reset asserted mid-fetch SHALL abort the fetch immediately; line buffer contents SHALL NOT be cleared.

Configuration
REQ-032 Macro GLYPH_FETCH_CURSOR_EN defined: ports cursor_en (1), cursor_col (7) and cursor_row (5) SHALL exist, and when cursor_en=1 the cell at (cursor_row, cursor_col) SHALL be stored as font_row XOR 0xFF.
REQ-033 Macro not defined: those ports SHALL be absent and font_row SHALL be stored unmodified.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the default COLS/ROWS values and the glyph width/height (8/16).
REQ-035 A single sub-module, glyph_line_buf, SHALL implement the dual-bank line buffer (one write port, one registered read port).

Verification
REQ-036 fetch_row=2, scanline=5: char_addr SHALL be 160..239 over 80 cycles, and done SHALL be high the single cycle after edge E0+82.
REQ-037 Character RAM model returns 0x41 for all columns, font ROM model returns 0x18: after a bank swap, disp_bits SHALL be 0x18 for disp_col=0..79 and 0x00 for disp_col=100.
REQ-038 Second line_start at E0+10: overrun SHALL become 1, the fetch SHALL complete at the original time, and no extra bank toggle SHALL occur.
REQ-039 rst_n low at E0+40: busy=0 and char_rd_en=0 immediately; the next line_start SHALL fetch normally from column 0.
REQ-040 With GLYPH_FETCH_CURSOR_EN defined, cursor at (row 2, col 7), font_row=0x18: column 7 SHALL read 0xE7 and all other columns SHALL read 0x18.
